// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller arbitrating the fetch port (IF) and the data
// port (MEM) onto one memory. One access per IDLE -> ACCESS -> RESP round, data port
// has priority. Big-endian lane mapping; loads are aligned and sign/zero-extended,
// stores are replicated across lanes.
// Optional feature: define MEM_CTRL_ALIGN_CHECK_EN to suppress misaligned halfword/word
// data accesses and report them on dm_misalign instead of dm_ack.
module mem_ctrl #(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_ack,
    output logic [31:0]          if_inst,
    input  logic                 dm_req,
    input  logic [2:0]           dm_op,
    input  logic [AddrWidth-1:0] dm_addr,
    input  logic [31:0]          dm_wdata,
    output logic                 dm_ack,
    output logic [31:0]          dm_rdata,
    output logic                 dm_misalign,
    output logic                 stall_req,
    output logic                 mem_ce,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [3:0]           mem_byte_slct,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i
);

    localparam int unsigned DataWidth = 32;
    localparam int unsigned ByteLanes = DataWidth / 8;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic                   gnt_dm, gnt_dm_d;
    logic [2:0]             op_q, op_d;
    logic [1:0]             off_q, off_d;
    logic                   misal_q, misal_d;
    logic                   misal_c;
    logic                   stall_c;
    logic                   mem_ce_d, mem_we_d;
    logic [AddrWidth-1:0]   mem_addr_d;
    logic [ByteLanes-1:0]   mem_byte_slct_d;
    logic [DataWidth-1:0]   mem_data_o_d;
    logic                   if_ack_d, dm_ack_d, dm_misalign_d;
    logic [DataWidth-1:0]   if_inst_d, dm_rdata_d;
    logic                   unused_if_low;

    // Fetch addresses are word aligned; their low bits carry no information.
    assign unused_if_low = ^if_addr[1:0];

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Big-endian lane enables: offset 0 is the most significant lane.
    function automatic logic [ByteLanes-1:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   lane_sel = 4'b1000 >> off;
            OP_SH:   lane_sel = off[1] ? 4'b0011 : 4'b1100;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [DataWidth-1:0] store_data(input logic [2:0] op,
                                                        input logic [DataWidth-1:0] wdata);
        case (op)
            OP_SB:   store_data = {4{wdata[7:0]}};
            OP_SH:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    // Pick the addressed lane(s) and extend to a full word; stores return zero.
    function automatic logic [DataWidth-1:0] load_data(input logic [2:0] op, input logic [1:0] off,
                                                       input logic [DataWidth-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   load_data = {{24{b[7]}}, b};
            OP_LBU:  load_data = {24'h0, b};
            OP_LH:   load_data = {{16{h[15]}}, h};
            OP_LHU:  load_data = {16'h0, h};
            OP_LW:   load_data = word;
            default: load_data = '0;
        endcase
    endfunction

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    // Flag halfword/word data accesses whose low address bits break natural alignment.
    always_comb begin
        misal_c = 1'b0;
        case (dm_op)
            OP_LH, OP_LHU, OP_SH: misal_c = dm_addr[0];
            OP_LW, OP_SW:         misal_c = |dm_addr[1:0];
            default:              misal_c = 1'b0;
        endcase
    end
`else
    assign misal_c = 1'b0;
`endif

    assign stall_req = stall_c;

    // State and registered outputs; reset drops the memory strobes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gnt_dm        <= 1'b0;
            op_q          <= 3'd0;
            off_q         <= 2'd0;
            misal_q       <= 1'b0;
            mem_ce        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_byte_slct <= '0;
            mem_data_o    <= '0;
            if_ack        <= 1'b0;
            dm_ack        <= 1'b0;
            dm_misalign   <= 1'b0;
            if_inst       <= '0;
            dm_rdata      <= '0;
        end else begin
            state         <= state_d;
            gnt_dm        <= gnt_dm_d;
            op_q          <= op_d;
            off_q         <= off_d;
            misal_q       <= misal_d;
            mem_ce        <= mem_ce_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_byte_slct <= mem_byte_slct_d;
            mem_data_o    <= mem_data_o_d;
            if_ack        <= if_ack_d;
            dm_ack        <= dm_ack_d;
            dm_misalign   <= dm_misalign_d;
            if_inst       <= if_inst_d;
            dm_rdata      <= dm_rdata_d;
        end
    end

    // Next state, grant capture, memory drive for ACCESS and ack generation for RESP.
    always_comb begin
        state_d         = state;
        gnt_dm_d        = gnt_dm;
        op_d            = op_q;
        off_d           = off_q;
        misal_d         = misal_q;
        mem_ce_d        = 1'b0;
        mem_we_d        = 1'b0;
        mem_addr_d      = '0;
        mem_byte_slct_d = '0;
        mem_data_o_d    = '0;
        if_ack_d        = 1'b0;
        dm_ack_d        = 1'b0;
        dm_misalign_d   = 1'b0;
        if_inst_d       = if_inst;
        dm_rdata_d      = dm_rdata;
        stall_c         = 1'b0;
        case (state)
            IDLE: begin
                stall_c = dm_req | if_req;
                if (dm_req) begin
                    gnt_dm_d        = 1'b1;
                    op_d            = dm_op;
                    off_d           = dm_addr[1:0];
                    misal_d         = misal_c;
                    mem_ce_d        = ~misal_c;
                    mem_we_d        = ~misal_c & is_store(dm_op);
                    mem_addr_d      = {dm_addr[AddrWidth-1:2], 2'b00};
                    mem_byte_slct_d = lane_sel(dm_op, dm_addr[1:0]);
                    mem_data_o_d    = store_data(dm_op, dm_wdata);
                    state_d         = ACCESS;
                end else if (if_req) begin
                    gnt_dm_d        = 1'b0;
                    op_d            = OP_LW;
                    off_d           = 2'd0;
                    misal_d         = 1'b0;
                    mem_ce_d        = 1'b1;
                    mem_addr_d      = {if_addr[AddrWidth-1:2], 2'b00};
                    mem_byte_slct_d = 4'b1111;
                    state_d         = ACCESS;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                state_d = RESP;
                if (gnt_dm) begin
                    if (misal_q) begin
                        dm_misalign_d = 1'b1;
                        dm_rdata_d    = '0;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = load_data(op_q, off_q, mem_data_i);
                    end
                end else begin
                    if_ack_d  = 1'b1;
                    if_inst_d = mem_data_i;
                end
            end
            RESP: begin
                stall_c = gnt_dm ? if_req : dm_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural word memory, scoreboard queue of
// expected load results, one task per scenario.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_inst;
    logic        dm_req;
    logic [2:0]  dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_misalign;
    logic        stall_req;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_slct;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    logic [31:0] mem [0:63];
    logic        preload;

    mem_ctrl #(.AddrWidth(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
        .dm_req(dm_req), .dm_op(dm_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_misalign(dm_misalign),
        .stall_req(stall_req),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_byte_slct(mem_byte_slct), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read on ce/addr, byte-enabled write at the clock edge.
    assign mem_data_i = mem_ce ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hDEADBEEF;
            mem[1] <= 32'hCAFEF00D;
            mem[8] <= 32'hA5A5A5A5;
        end else if (mem_ce && mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_slct[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_data_o[8*i +: 8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one data request and collect what the DUT did; lat = -1 if no response.
    task automatic dm_xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output int lat, output logic misal_seen,
                           output logic ce_seen, output logic [3:0] slct, output logic [31:0] wdo,
                           output logic [31:0] maddr);
        @(negedge clk);
        dm_req = 1'b1; dm_op = op; dm_addr = addr; dm_wdata = wd;
        rdata = 32'hx; lat = -1; misal_seen = 1'b0; ce_seen = 1'b0;
        slct = 4'h0; wdo = 32'h0; maddr = 32'h0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ce) begin
                ce_seen = 1'b1; slct = mem_byte_slct; wdo = mem_data_o; maddr = mem_addr;
            end
            if (dm_misalign) misal_seen = 1'b1;
            if (dm_ack || dm_misalign) begin
                lat = n; rdata = dm_rdata;
                break;
            end
        end
        dm_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; preload = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_op = 3'd0; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL reset_mem_ce got=%b exp=0", mem_ce); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if ({dm_ack, if_ack, dm_misalign, stall_req} !== 4'b0)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {dm_ack, if_ack, dm_misalign, stall_req}); end
        checks++; if ({mem_addr, mem_byte_slct, mem_data_o, dm_rdata, if_inst} !== 132'h0)
            begin failures++; $display("FAIL reset_buses addr=%h slct=%h wd=%h rd=%h inst=%h", mem_addr, mem_byte_slct, mem_data_o, dm_rdata, if_inst); end
        rst = 1'b1; preload = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd, wdo, ma, e;
        logic [3:0]  sl;
        logic        mis, ce;
        int          lat;
        exp_q.push_back(32'h0);
        dm_xfer(3'd7, 32'h10, 32'h12345678, rd, lat, mis, ce, sl, wdo, ma);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL sw_ack_rdata got=%h exp=%h", rd, e); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if ({sl, wdo, ma} !== {4'hF, 32'h12345678, 32'h10})
            begin failures++; $display("FAIL sw_drive slct=%h wd=%h addr=%h exp F/12345678/00000010", sl, wdo, ma); end
        exp_q.push_back(32'h12345678);
        dm_xfer(3'd4, 32'h10, 32'h0, rd, lat, mis, ce, sl, wdo, ma);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL lw_rdata got=%h exp=%h", rd, e); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    endtask

    // Runs a table of loads through the scoreboard.
    task automatic run_loads(input logic [2:0] ops[], input logic [31:0] adrs[], input logic [31:0] exps[]);
        logic [31:0] rd, wdo, ma, e;
        logic [3:0]  sl;
        logic        mis, ce;
        int          lat;
        for (int i = 0; i < ops.size(); i++) begin
            exp_q.push_back(exps[i]);
            dm_xfer(ops[i], adrs[i], 32'h0, rd, lat, mis, ce, sl, wdo, ma);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e || lat !== 2) begin
                failures++;
                $display("FAIL load[%0d] op=%0d addr=%h got=%h lat=%0d exp=%h lat=2", i, ops[i], adrs[i], rd, lat, e);
            end
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, wdo, ma;
        logic [3:0]  sl;
        logic        mis, ce;
        int          lat;
        dm_xfer(3'd5, 32'h11, 32'h000000FF, rd, lat, mis, ce, sl, wdo, ma);
        checks++; if ({sl, wdo} !== {4'b0100, 32'hFFFFFFFF})
            begin failures++; $display("FAIL sb_drive slct=%b wd=%h exp 0100/ffffffff", sl, wdo); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sb_ack_rdata got=%h exp=0", rd); end
        run_loads('{3'd0, 3'd1, 3'd4, 3'd0, 3'd1},
                  '{32'h11, 32'h11, 32'h10, 32'h10, 32'h13},
                  '{32'hFFFFFFFF, 32'h000000FF, 32'h12FF5678, 32'h00000012, 32'h00000078});
    endtask

    task automatic test_half();
        logic [31:0] rd, wdo, ma;
        logic [3:0]  sl;
        logic        mis, ce;
        int          lat;
        dm_xfer(3'd6, 32'h12, 32'h00008001, rd, lat, mis, ce, sl, wdo, ma);
        checks++; if ({sl, wdo} !== {4'b0011, 32'h80018001})
            begin failures++; $display("FAIL sh_lo_drive slct=%b wd=%h exp 0011/80018001", sl, wdo); end
        run_loads('{3'd2, 3'd3, 3'd4, 3'd2},
                  '{32'h12, 32'h12, 32'h10, 32'h10},
                  '{32'hFFFF8001, 32'h00008001, 32'h12FF8001, 32'h000012FF});
        dm_xfer(3'd6, 32'h10, 32'h1234ABCD, rd, lat, mis, ce, sl, wdo, ma);
        checks++; if ({sl, wdo} !== {4'b1100, 32'hABCDABCD})
            begin failures++; $display("FAIL sh_hi_drive slct=%b wd=%h exp 1100/abcdabcd", sl, wdo); end
        run_loads('{3'd3, 3'd2, 3'd0, 3'd4},
                  '{32'h10, 32'h10, 32'h10, 32'h10},
                  '{32'h0000ABCD, 32'hFFFFABCD, 32'hFFFFFFAB, 32'hABCD8001});
    endtask

    task automatic test_reset_abort();
        logic seen;
        @(negedge clk);
        dm_req = 1'b1; dm_op = 3'd7; dm_addr = 32'h20; dm_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({mem_ce, mem_we} !== 2'b11) begin failures++; $display("FAIL abort_pre_access ce_we=%b exp=11", {mem_ce, mem_we}); end
        #1 rst = 1'b0; dm_req = 1'b0;
        #1;
        checks++; if ({mem_ce, mem_we} !== 2'b00) begin failures++; $display("FAIL abort_async_off ce_we=%b exp=00", {mem_ce, mem_we}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (dm_ack || if_ack || dm_misalign) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", seen); end
        run_loads('{3'd4}, '{32'h20}, '{32'hA5A5A5A5});
    endtask

    task automatic test_back_to_back();
        logic [7:0]  st;
        int          dj, ij;
        logic [31:0] drd, ird;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_op = 3'd4; dm_addr = 32'h4;
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'hDEADBEEF);
        #1 st = 8'h0; st[0] = stall_req;
        dj = -1; ij = -1; drd = 32'h0; ird = 32'h0;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            @(negedge clk);
            st[j] = stall_req;
            if (dm_ack && dj < 0) begin dj = j; drd = dm_rdata; dm_req = 1'b0; end
            if (if_ack && ij < 0) begin ij = j; ird = if_inst; if_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        checks++; if (dj !== 2) begin failures++; $display("FAIL arb_dm_ack_cycle got=%0d exp=2", dj); end
        checks++; if (ij !== 5) begin failures++; $display("FAIL arb_if_ack_cycle got=%0d exp=5", ij); end
        checks++; if (st[5:0] !== 6'b011111) begin failures++; $display("FAIL arb_stall k..k+5 got=%b exp=011111", st[5:0]); end
        checks++; if (drd !== exp_q[0]) begin failures++; $display("FAIL arb_dm_rdata got=%h exp=%h", drd, exp_q[0]); end
        void'(exp_q.pop_front());
        checks++; if (ird !== exp_q[0]) begin failures++; $display("FAIL arb_if_inst got=%h exp=%h", ird, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_misalign();
        logic [31:0] rd, wdo, ma;
        logic [3:0]  sl;
        logic        mis, ce;
        int          lat;
        dm_xfer(3'd4, 32'h6, 32'h0, rd, lat, mis, ce, sl, wdo, ma);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        checks++; if ({mis, ce} !== 2'b10) begin failures++; $display("FAIL misalign_flags mis_ce=%b exp=10", {mis, ce}); end
        checks++; if (rd !== 32'h0 || lat !== 2) begin failures++; $display("FAIL misalign_resp rd=%h lat=%0d exp 0/2", rd, lat); end
        checks++; if (dm_ack !== 1'b0) begin failures++; $display("FAIL misalign_no_ack got=%b exp=0", dm_ack); end
`else
        checks++; if (rd !== 32'hCAFEF00D || lat !== 2) begin failures++; $display("FAIL unaligned_lw rd=%h lat=%0d exp cafef00d/2", rd, lat); end
        checks++; if ({mis, ma} !== {1'b0, 32'h4}) begin failures++; $display("FAIL unaligned_lw_addr mis=%b addr=%h exp 0/00000004", mis, ma); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte();
        test_half();
        test_reset_abort();
        test_back_to_back();
        test_misalign();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
